// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: instruction field layout,
// opcode set and the per-opcode operand/writeback classification helpers.
package cpu_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 3;
    localparam int unsigned IW_DEF = 16;

    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_W   = 6;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_NOP  = 4'd15
    } opcode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ofs_state_e;

    // Undefined encodings (8..14) collapse to NOP so they never read or write registers.
    function automatic opcode_e decode_op(input logic [3:0] raw);
        case (raw)
            4'd0:    return OP_ADD;
            4'd1:    return OP_SUB;
            4'd2:    return OP_AND;
            4'd3:    return OP_OR;
            4'd4:    return OP_ADDI;
            4'd5:    return OP_LD;
            4'd6:    return OP_ST;
            4'd7:    return OP_BEQ;
            default: return OP_NOP;
        endcase
    endfunction

    function automatic logic uses_rs1(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_BEQ};
    endfunction

    function automatic logic uses_rs2(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ};
    endfunction

    function automatic logic writes_rd(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD};
    endfunction

    function automatic logic uses_imm(input opcode_e op);
        return op inside {OP_ADDI, OP_LD};
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Selects the freshest value for one source register: EX result, then MEM,
// then the WB write in flight, falling back to the register file read data.
module operand_forward_mux
    import cpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0] i_src,
    input  logic          i_ex_en,
    input  logic [AW-1:0] i_ex_rd,
    input  logic [DW-1:0] i_ex_data,
    input  logic          i_mem_en,
    input  logic [AW-1:0] i_mem_rd,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_wb_en,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [DW-1:0] i_wb_data,
    input  logic [DW-1:0] i_rdata,
    output logic [DW-1:0] o_data
);

    always_comb begin
        o_data = i_rdata;
        if (i_ex_en && (i_ex_rd == i_src)) begin
            o_data = i_ex_data;
        end else if (i_mem_en && (i_mem_rd == i_src)) begin
            o_data = i_mem_data;
        end else if (i_wb_en && (i_wb_rd == i_src)) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID stage: decodes the IF/ID instruction, reads and forwards operands, stalls
// on load-use hazards and registers the ID/EX bundle behind a valid/ready handshake.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned IW = IW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    input  logic          flush,
    output logic [AW-1:0] srcreg1,
    output logic [AW-1:0] srcreg2,
    input  logic [DW-1:0] rdata1,
    input  logic [DW-1:0] rdata2,
    input  logic          ex_valid,
    input  logic          ex_we,
    input  logic          ex_is_load,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_result,
    input  logic          mem_valid,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_write,
    input  logic [AW-1:0] wb_destreg,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_opcode,
    output logic [AW-1:0] out_rd,
    output logic [DW-1:0] out_opa,
    output logic [DW-1:0] out_opb,
    output logic [DW-1:0] out_stdata,
    output logic          out_we,
    output logic          out_is_load,
    output logic          out_is_store,
    output logic          out_is_branch
);

    opcode_e       w_op;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_fwd1;
    logic [DW-1:0] w_fwd2;
    logic          w_ex_en;
    logic          w_mem_en;
    logic          w_hazard;
    logic          w_accept;

    ofs_state_e    r_state;
    opcode_e       r_opcode;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_opa;
    logic [DW-1:0] r_opb;
    logic [DW-1:0] r_stdata;
    logic          r_we;
    logic          r_is_load;
    logic          r_is_store;
    logic          r_is_branch;

    assign w_op    = decode_op(in_instr[OPC_LSB +: 4]);
    assign srcreg1 = in_instr[RS1_LSB +: AW];
    assign srcreg2 = in_instr[RS2_LSB +: AW];
    assign w_imm   = {{(DW-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

    // A load in EX has no data yet, so it is excluded from EX bypass and stalls instead.
    assign w_ex_en  = ex_valid & ex_we & ~ex_is_load;
    assign w_mem_en = mem_valid & mem_we;

    assign w_hazard = in_valid & ex_valid & ex_is_load & ex_we &
                      ((uses_rs1(w_op) & (ex_rd == srcreg1)) |
                       (uses_rs2(w_op) & (ex_rd == srcreg2)));

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = reset & (~out_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept  = in_valid & in_ready;

    operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd1 (
        .i_src      (srcreg1),
        .i_ex_en    (w_ex_en),
        .i_ex_rd    (ex_rd),
        .i_ex_data  (ex_result),
        .i_mem_en   (w_mem_en),
        .i_mem_rd   (mem_rd),
        .i_mem_data (mem_result),
        .i_wb_en    (wb_write),
        .i_wb_rd    (wb_destreg),
        .i_wb_data  (wb_data),
        .i_rdata    (rdata1),
        .o_data     (w_fwd1)
    );

    operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd2 (
        .i_src      (srcreg2),
        .i_ex_en    (w_ex_en),
        .i_ex_rd    (ex_rd),
        .i_ex_data  (ex_result),
        .i_mem_en   (w_mem_en),
        .i_mem_rd   (mem_rd),
        .i_mem_data (mem_result),
        .i_wb_en    (wb_write),
        .i_wb_rd    (wb_destreg),
        .i_wb_data  (wb_data),
        .i_rdata    (rdata2),
        .o_data     (w_fwd2)
    );

    // Flush beats accept; a hazard simply blocks accept, so a draining output becomes a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_EMPTY;
            r_opcode    <= OP_NOP;
            r_rd        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_stdata    <= '0;
            r_we        <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_branch <= 1'b0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state     <= ST_FULL;
            r_opcode    <= w_op;
            r_rd        <= in_instr[RD_LSB +: AW];
            r_opa       <= w_fwd1;
            r_opb       <= uses_imm(w_op) ? w_imm : w_fwd2;
            r_stdata    <= w_fwd2;
            r_we        <= writes_rd(w_op);
            r_is_load   <= (w_op == OP_LD);
            r_is_store  <= (w_op == OP_ST);
            r_is_branch <= (w_op == OP_BEQ);
        end else if (out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_opcode    = r_opcode;
    assign out_rd        = r_rd;
    assign out_opa       = r_opa;
    assign out_opb       = r_opb;
    assign out_stdata    = r_stdata;
    assign out_we        = r_we;
    assign out_is_load   = r_is_load;
    assign out_is_store  = r_is_store;
    assign out_is_branch = r_is_branch;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized scoreboard bench for operand_fetch_stage with a register-file
// and pipeline-state reference model kept in the bench.
module tb_operand_fetch_stage;

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [7:0] std;
        logic       we;
        logic       ld;
        logic       st;
        logic       br;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush;
    logic [15:0] in_instr;
    logic [2:0]  srcreg1, srcreg2;
    logic [7:0]  rdata1, rdata2;
    logic        ex_valid, ex_we, ex_is_load;
    logic [2:0]  ex_rd;
    logic [7:0]  ex_result;
    logic        mem_valid, mem_we;
    logic [2:0]  mem_rd;
    logic [7:0]  mem_result;
    logic        wb_write;
    logic [2:0]  wb_destreg;
    logic [7:0]  wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd;
    logic [7:0]  out_opa, out_opb, out_stdata;
    logic        out_we, out_is_load, out_is_store, out_is_branch;

    logic [7:0]  rf [8];
    bundle_t     sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign rdata1 = rf[in_instr[8:6]];
    assign rdata2 = rf[in_instr[5:3]];

    operand_fetch_stage #(.DW(8), .AW(3), .IW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .srcreg1(srcreg1), .srcreg2(srcreg2),
        .rdata1(rdata1), .rdata2(rdata2), .ex_valid(ex_valid), .ex_we(ex_we),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_write(wb_write), .wb_destreg(wb_destreg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_opa(out_opa), .out_opb(out_opb), .out_stdata(out_stdata),
        .out_we(out_we), .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Newest producer wins: EX (non-load), then MEM, then the WB write, then the array.
    function automatic logic [7:0] fwd(input logic [2:0] src);
        if (ex_valid && ex_we && !ex_is_load && ex_rd == src) return ex_result;
        if (mem_valid && mem_we && mem_rd == src) return mem_result;
        if (wb_write && wb_destreg == src) return wb_data;
        return rf[src];
    endfunction

    function automatic bundle_t model(input logic [15:0] ins);
        bundle_t b;
        int unsigned raw = ins[15:12];
        logic [7:0] imm = {{2{ins[5]}}, ins[5:0]};
        b.op  = (raw <= 7) ? ins[15:12] : 4'd15;
        b.rd  = ins[11:9];
        b.opa = fwd(ins[8:6]);
        b.std = fwd(ins[5:3]);
        b.opb = (raw == 4 || raw == 5) ? imm : b.std;
        b.we  = (raw <= 5);
        b.ld  = (raw == 5);
        b.st  = (raw == 6);
        b.br  = (raw == 7);
        return b;
    endfunction

    function automatic logic exp_hazard(input logic [15:0] ins);
        int unsigned raw = ins[15:12];
        logic u1 = (raw <= 7);
        logic u2 = (raw <= 3) || raw == 6 || raw == 7;
        return in_valid && ex_valid && ex_is_load && ex_we &&
               ((u1 && ex_rd == ins[8:6]) || (u2 && ex_rd == ins[5:3]));
    endfunction

    // Monitor: every transfer on the output side must match the oldest expected bundle.
    initial begin
        bundle_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_transfer", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_opcode", out_opcode, e.op);
                    chk("out_rd", out_rd, e.rd);
                    chk("out_opa", out_opa, e.opa);
                    chk("out_opb", out_opb, e.opb);
                    chk("out_stdata", out_stdata, e.std);
                    chk("out_we", out_we, e.we);
                    chk("out_is_load", out_is_load, e.ld);
                    chk("out_is_store", out_is_store, e.st);
                    chk("out_is_branch", out_is_branch, e.br);
                end
            end
        end
    end

    initial begin
        logic    m_ov = 1'b0;
        logic    p_reset = 1'b0, p_flush = 1'b0, p_ordy = 1'b0, p_acc = 1'b0, p_inv = 1'b0;
        logic    p_wb = 1'b0;
        logic [2:0] p_wb_rd = '0;
        logic [7:0] p_wb_d = '0;
        bundle_t p_exp;
        logic    hz, rdy, drain;
        int unsigned raw;
        const int unsigned NCYC = 3000;

        foreach (rf[i]) rf[i] = 8'($urandom);
        reset = 1'b0; in_valid = 1'b0; in_instr = 16'hF000; flush = 1'b0; out_ready = 1'b0;
        ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_result = '0;
        mem_valid = 1'b0; mem_we = 1'b0; mem_rd = '0; mem_result = '0;
        wb_write = 1'b0; wb_destreg = '0; wb_data = '0;
        p_exp = model(16'hF000);

        for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            // Retire the effects of the edge that just happened.
            if (p_wb) rf[p_wb_rd] = p_wb_d;
            if (!p_reset) begin
                if (m_ov && !p_ordy && sb.size() > 0) void'(sb.pop_front());
                m_ov = 1'b0;
                chk("rst_opcode", out_opcode, 32'd15);
                chk("rst_opa", out_opa, 32'd0);
                chk("rst_opb", out_opb, 32'd0);
                chk("rst_rd", out_rd, 32'd0);
                chk("rst_flags", {out_we, out_is_load, out_is_store, out_is_branch, out_stdata}, 32'd0);
            end else if (p_flush) begin
                if (m_ov && !p_ordy && sb.size() > 0) void'(sb.pop_front());
                m_ov = 1'b0;
            end else if (p_acc) begin
                sb.push_back(p_exp);
                m_ov = 1'b1;
            end else if (p_ordy) begin
                m_ov = 1'b0;
            end
            chk("out_valid", out_valid, m_ov);

            drain = (cyc >= NCYC - 12);
            if (!(p_inv && !p_acc && !p_flush && p_reset)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                raw = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
                in_instr = {4'(raw), 12'($urandom)};
            end
            reset      = drain ? 1'b1 : ($urandom_range(0, 149) != 0);
            flush      = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
            out_ready  = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (drain) in_valid = 1'b0;
            ex_valid   = $urandom_range(0, 1) != 0;
            ex_we      = $urandom_range(0, 3) != 0;
            ex_is_load = $urandom_range(0, 4) == 0;
            ex_rd      = 3'($urandom);
            ex_result  = 8'($urandom);
            mem_valid  = $urandom_range(0, 1) != 0;
            mem_we     = $urandom_range(0, 3) != 0;
            mem_rd     = 3'($urandom);
            mem_result = 8'($urandom);
            wb_write   = $urandom_range(0, 1) != 0;
            wb_destreg = 3'($urandom);
            wb_data    = 8'($urandom);
            #1;

            hz  = exp_hazard(in_instr);
            rdy = reset && (!m_ov || out_ready) && !hz && !flush;
            chk("in_ready", in_ready, rdy);
            chk("srcreg1", srcreg1, in_instr[8:6]);
            chk("srcreg2", srcreg2, in_instr[5:3]);

            p_exp   = model(in_instr);
            p_acc   = in_valid && rdy;
            p_inv   = in_valid;
            p_reset = reset;
            p_flush = flush;
            p_ordy  = out_ready;
            p_wb    = wb_write;
            p_wb_rd = wb_destreg;
            p_wb_d  = wb_data;
        end

        @(posedge clk);
        #6;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch (ID) stage of the 8-bit pipelined core; the read-side client of the 8x8 register file.
- Accepts a 16-bit instruction from IF/ID, drives srcreg1/srcreg2, captures rdata1/rdata2 and applies EX/MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles. Emits the registered ID/EX bundle through a valid/ready handshake.

Parameters:
- DW, 8, datapath width
- AW, 3, register index width
- IW, 16, instruction width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  IF/ID instruction valid
- in_instr  in  IW  instruction
- in_ready  out  1  stage accepts in_instr this cycle
- flush  in  1  branch redirect; kill held and incoming instruction
- srcreg1  out  AW  register file read index 1 (combinational from in_instr[8:6])
- srcreg2  out  AW  register file read index 2 (combinational from in_instr[5:3])
- rdata1  in  DW  register file read data 1 (combinational read)
- rdata2  in  DW  register file read data 2
- ex_valid, ex_we, ex_is_load  in  1 each  EX-stage status
- ex_rd  in  AW; ex_result  in  DW
- mem_valid, mem_we  in  1 each; mem_rd  in  AW; mem_result  in  DW
- wb_write  in  1; wb_destreg  in  AW; wb_data  in  DW  (same signals that drive the register file write port)
- out_valid  out  1  ID/EX bundle valid
- out_ready  in  1  EX accepts bundle
- out_opcode  out  4; out_rd  out  AW; out_opa  out  DW; out_opb  out  DW; out_stdata  out  DW
- out_we, out_is_load, out_is_store, out_is_branch  out  1 each

Behaviour:
- Encoding: opcode = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm6 = [5:0] sign-extended to 8 bits.
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, ADDI=4, LD=5, ST=6, BEQ=7, NOP=15.
- Undefined opcodes decode as NOP.
- Operand use: uses_rs1 for 0-7. uses_rs2 for 0-3, 6, 7.
- out_opb = imm for ADDI and LD; otherwise the forwarded rs2. out_stdata = forwarded rs2 (ST).
- out_we = 1 for 0-5.
- No hardwired-zero register.
- Forwarding per source, priority EX > MEM > WB > rdata:
  - EX matches when ex_valid & ex_we & !ex_is_load & ex_rd == src.
  - MEM matches when mem_valid & mem_we & mem_rd == src.
  - WB matches when wb_write & wb_destreg == src. This bypass is required because the register file writes at the edge.
- Load-use hazard = in_valid & ex_valid & ex_is_load & ex_we & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)).
- Handshake:
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
  - Accept occurs when in_valid & in_ready. Latency is 1 cycle: the bundle is registered at that edge and out_valid = 1 next cycle.
  - out_valid high & out_ready low: all out_* held stable; in_ready = 0.
  - Hazard with the output draining (!out_valid | out_ready): load out_valid = 0 (bubble). The instruction stays at the input and re-evaluates next cycle once the load has moved to MEM (MEM forwarding then supplies it).
- State machine:
  - EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept & out_ready. FULL -> EMPTY on out_ready & !accept. FULL -> FULL hold on !out_ready.
- flush: at the edge, out_valid <= 0 and the incoming instruction is not accepted. Flush overrides accept, hazard and hold.
- Reset (reset == 0 at the edge):
  - out_valid = 0, all out_* data = 0, out_opcode = NOP, state EMPTY.
  - in_ready forced 0 while reset is low.
  - Reset mid-hold discards the held bundle.
- srcreg1/srcreg2 follow in_instr combinationally, independent of valid.

Decomposition:
- Package cpu_pkg: opcode constants, field positions, DW/AW, functions uses_rs1(op), uses_rs2(op), writes_rd(op), uses_imm(op).
- One sub-module: operand_forward_mux (one source index plus the three bypass tuples and rdata -> forwarded value), instantiated twice.

Test Plan:
- Reg file r1=42 and r2=99 with no hazards; ADD r3,r1,r2 -> one cycle later out_valid=1, out_opa=42, out_opb=99, out_rd=3, out_we=1.
- EX ADD writing r1=7 while MEM writes r1=5 and WB writes r1=3; ADD r4,r1,r1 -> out_opa=out_opb=7. Repeat without EX -> 5; with WB only -> 3.
- EX LD r2 valid; ADD r5,r2,r0 -> in_ready=0 and one bubble cycle (out_valid=0). Next cycle with MEM r2=0x80 -> out_opa=0x80.
- ADDI r6,r1,imm6=0x3F (-1) -> out_opb=0xFF. LD r1 as EX with a following ST r1 source -> hazard asserted.
- out_ready held 0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0. Then out_ready=1 -> next instruction accepted the same edge.
- flush coincident with an accept -> out_valid=0 next cycle. Reset low while FULL -> out_valid=0, out_opcode=15 after one edge.
